// File: rtl/seg_scan_driver.sv
// Binary-to-BCD converter (double dabble) feeding a multiplexed 5-digit 7-segment scanner.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seg_scan_driver #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd,
    output logic [6:0]  seg,
    output logic [4:0]  an
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] DIV_MAX = 16'(SCAN_DIV - 1);

    state_t      state_r;
    logic [15:0] shift_r;
    logic [19:0] scratch_r;
    logic [4:0]  bit_cnt_r;
    logic [15:0] presc_r;
    logic [2:0]  idx_r;
    logic [19:0] adj_s;
    logic [3:0]  digit_s;
    logic [6:0]  seg_next_s;

    function automatic logic [19:0] dabble_adjust(input logic [19:0] s);
        logic [19:0] r;
        logic [3:0]  nib;
        r = 20'd0;
        for (int i = 0; i < 5; i++) begin
            nib = s[4*i +: 4];
            if (nib >= 4'd5) begin
                r[4*i +: 4] = nib + 4'd3;
            end else begin
                r[4*i +: 4] = nib;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = 7'h3F;
            4'd1:    r = 7'h06;
            4'd2:    r = 7'h5B;
            4'd3:    r = 7'h4F;
            4'd4:    r = 7'h66;
            4'd5:    r = 7'h6D;
            4'd6:    r = 7'h7D;
            4'd7:    r = 7'h07;
            4'd8:    r = 7'h7F;
            4'd9:    r = 7'h6F;
            default: r = 7'h00;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] digit_of(input logic [19:0] b, input logic [2:0] i);
        logic [3:0] r;
        case (i)
            3'd0:    r = b[3:0];
            3'd1:    r = b[7:4];
            3'd2:    r = b[11:8];
            3'd3:    r = b[15:12];
            3'd4:    r = b[19:16];
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] one_hot(input logic [2:0] i);
        logic [4:0] r;
        case (i)
            3'd0:    r = 5'b00001;
            3'd1:    r = 5'b00010;
            3'd2:    r = 5'b00100;
            3'd3:    r = 5'b01000;
            3'd4:    r = 5'b10000;
            default: r = 5'b00001;
        endcase
        return r;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Digit i is blank when it and every higher digit are zero; digit 0 always shows.
    function automatic logic digit_blank(input logic [19:0] b, input logic [2:0] i);
        logic r;
        case (i)
            3'd1:    r = (b[19:4] == 16'd0);
            3'd2:    r = (b[19:8] == 12'd0);
            3'd3:    r = (b[19:12] == 8'd0);
            3'd4:    r = (b[19:16] == 4'd0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    // Nibble correction applied before each shift of the conversion.
    always_comb begin
        adj_s = dabble_adjust(scratch_r);
    end

    // Segment pattern for the digit currently selected by the scan index.
    always_comb begin
        digit_s = digit_of(bcd, idx_r);
`ifdef LEADING_ZERO_BLANK_EN
        if (digit_blank(bcd, idx_r)) begin
            seg_next_s = 7'h00;
        end else begin
            seg_next_s = seg_decode(digit_s);
        end
`else
        seg_next_s = seg_decode(digit_s);
`endif
    end

    // Conversion FSM; bcd only changes in DONE so the display never sees partial results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= 20'd0;
            shift_r   <= 16'd0;
            scratch_r <= 20'd0;
            bit_cnt_r <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load) begin
                        shift_r   <= value;
                        scratch_r <= 20'd0;
                        bit_cnt_r <= 5'd0;
                        busy      <= 1'b1;
                        state_r   <= CONV;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CONV: begin
                    scratch_r <= {adj_s[18:0], shift_r[15]};
                    shift_r   <= {shift_r[14:0], 1'b0};
                    bit_cnt_r <= bit_cnt_r + 5'd1;
                    if (bit_cnt_r == 5'd15) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= CONV;
                    end
                end
                DONE: begin
                    bcd     <= scratch_r;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Scan prescaler and digit index, free-running regardless of conversions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= 16'd0;
            idx_r   <= 3'd0;
        end else if (presc_r >= DIV_MAX) begin
            presc_r <= 16'd0;
            if (idx_r >= 3'd4) begin
                idx_r <= 3'd0;
            end else begin
                idx_r <= idx_r + 3'd1;
            end
        end else begin
            presc_r <= presc_r + 16'd1;
        end
    end

    // Registered digit enable and segment outputs, updated together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 5'b00001;
            seg <= 7'h3F;
        end else begin
            an  <= one_hot(idx_r);
            seg <= seg_next_s;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: scoreboarded conversions, abort, held load and scan order.
module tb_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [6:0]  seg;
    logic [4:0]  an;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int done_expected = 0;
    logic [19:0] exp_q[$];

    seg_scan_driver #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .load  (load),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .seg   (seg),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int rem;
        r = 20'd0;
        rem = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest accepted conversion.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                chk("bcd_result", bcd, exp_q.pop_front());
                chk("busy_at_done", busy, 1'b0);
            end
        end
    end

    // Call at a negedge; load is accepted at the next posedge (edge k).
    task automatic run_conv(input logic [15:0] v, input int inj_at, input int rst_at);
        logic [19:0] prev;
        prev  = bcd;
        value = v;
        load  = 1'b1;
        @(posedge clk);
        exp_q.push_back(to_bcd(int'(v)));
        done_expected++;
        @(negedge clk);
        chk("busy_start", busy, 1'b1);
        for (int i = 1; i <= 17; i++) begin
            load  = (i == inj_at);
            value = (i == inj_at) ? 16'd999 : v;
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                chk("abort_bcd", bcd, 20'd0);
                chk("abort_busy", busy, 1'b0);
                chk("abort_an", an, 5'b00001);
                chk("abort_seg", seg, 7'h3F);
                void'(exp_q.pop_back());
                done_expected--;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                repeat (20) @(negedge clk);
                chk("abort_bcd_after", bcd, 20'd0);
                return;
            end
            @(posedge clk);
            @(negedge clk);
            if (i <= 16) begin
                chk("busy_conv", busy, 1'b1);
                if (i == 8) chk("bcd_held", bcd, prev);
            end else begin
                chk("busy_end", busy, 1'b0);
                chk("done_pulse", done, 1'b1);
                chk("bcd_final", bcd, to_bcd(int'(v)));
            end
        end
        load = 1'b0;
        @(negedge clk);
        chk("done_width", done, 1'b0);
    endtask

    logic [4:0] prev_an;
    logic       found;
    logic [6:0] seg_exp [5];
    logic [4:0] an_exp  [5];

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = 16'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_bcd", bcd, 20'd0);
        chk("rst_an", an, 5'b00001);
        chk("rst_seg", seg, 7'h3F);
        rst = 1'b0;

        run_conv(16'd12345, 0, 0);
        chk("bcd_12345", bcd, 20'h12345);
        run_conv(16'd65535, 0, 0);
        chk("bcd_65535", bcd, 20'h65535);
        run_conv(16'd0, 0, 0);
        chk("bcd_0", bcd, 20'h00000);
        run_conv(16'd9, 0, 0);
        chk("bcd_9", bcd, 20'h00009);
        run_conv(16'd12345, 5, 0);
        chk("bcd_ignore_load", bcd, 20'h12345);
        run_conv(16'd4321, 0, 8);

        // load held high: restart on the first edge back in IDLE
        value = 16'd7;
        load  = 1'b1;
        @(posedge clk);
        exp_q.push_back(to_bcd(7));
        done_expected++;
        repeat (17) @(posedge clk);
        @(posedge clk);
        exp_q.push_back(to_bcd(7));
        done_expected++;
        @(negedge clk);
        load = 1'b0;
        chk("held_restart_busy", busy, 1'b1);
        repeat (18) @(negedge clk);
        chk("held_idle_busy", busy, 1'b0);
        chk("bcd_7", bcd, 20'h00007);

        run_conv(16'd450, 0, 0);
        chk("bcd_450", bcd, 20'h00450);

        an_exp  = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
`ifdef LEADING_ZERO_BLANK_EN
        seg_exp = '{7'h3F, 7'h6D, 7'h66, 7'h00, 7'h00};
`else
        seg_exp = '{7'h3F, 7'h6D, 7'h66, 7'h3F, 7'h3F};
`endif
        found   = 1'b0;
        prev_an = an;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (an == 5'b00001 && prev_an == 5'b10000) begin
                found = 1'b1;
                break;
            end
            prev_an = an;
        end
        chk("scan_wrap_seen", found, 1'b1);
        for (int d = 0; d < 5; d++) begin
            chk("scan_an_first", an, an_exp[d]);
            chk("scan_seg_first", seg, seg_exp[d]);
            repeat (3) @(negedge clk);
            chk("scan_an_last", an, an_exp[d]);
            chk("scan_seg_last", seg, seg_exp[d]);
            @(negedge clk);
        end
        chk("scan_an_wrap", an, 5'b00001);

        chk("queue_empty", exp_q.size(), 32'd0);
        chk("done_count", done_seen, done_expected);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
